// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bus: code-memory read port, EX/MEM redirect, and the {IR, NPC} decode handshake.
interface mips_fetch_queue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_npc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  br_taken,
    input  br_target,
    input  id_ready,
    output id_valid,
    output id_ir,
    output id_npc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output br_taken,
    output br_target,
    output id_ready,
    input  id_valid,
    input  id_ir,
    input  id_npc
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS32 IF stage: owns the PC, prefetches code words into a small FIFO and presents {IR, NPC} to decode.
// Define FETCH_STATS_EN to add the fetch_cnt / flush_cnt statistics outputs.
module mips_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter logic [5:0]  HLT_OP = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  mips_fetch_queue_if.master    bus,
  output logic [PTR_W:0]        q_count,
  output logic                  halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  state_t           state;
  state_t           state_next;
  logic [31:0]      pc;
  logic [31:0]      pc_inc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      ir_mem  [DEPTH];
  logic [31:0]      npc_mem [DEPTH];
  logic             pop;
  logic             push;
  logic             is_hlt;

  assign pc_inc        = pc + 32'd1;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = (count != '0);
  assign bus.id_ir     = ir_mem[rd_ptr];
  assign bus.id_npc    = npc_mem[rd_ptr];
  assign q_count       = count;
  assign halted        = (state == HALTED);

  assign is_hlt = (bus.imem_rdata[31:26] == HLT_OP);
  assign pop    = bus.id_valid & bus.id_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push   = en & (state == FETCH) & ~bus.br_taken & ((count < FULL_COUNT) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.br_taken) begin
      state_next = FETCH;
    end else if (push && is_hlt) begin
      state_next = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ir_mem  <= '{default: '0};
      npc_mem <= '{default: '0};
    end else if (bus.br_taken) begin
      // Redirect flushes everything, including any pop decode made this cycle.
      pc     <= bus.br_target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ir_mem[wr_ptr]  <= bus.imem_rdata;
        npc_mem[wr_ptr] <= pc_inc;
        wr_ptr          <= wr_ptr + 1'b1;
        pc              <= pc_inc;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (bus.br_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Randomised and directed bench for mips_fetch_queue against a queue-based fetch model.
module tb_mips_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  q_count;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  mips_fetch_queue_if bus ();

  logic [31:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  mips_fetch_queue #(
    .DEPTH (4),
    .PTR_W (2),
    .HLT_OP(6'b111111)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus.master),
    .q_count (q_count),
    .halted  (halted)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: PC, queue of {ir, npc}, halt flag, statistics.
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  bit          m_halted;
  int          m_fetch;
  int          m_flush;
  int          checks = 0;
  int          errors = 0;

  task automatic drive(input bit e, input bit rdy, input bit br, input logic [31:0] tgt);
    en            = e;
    bus.id_ready  = rdy;
    bus.br_taken  = br;
    bus.br_target = tgt;
  endtask

  task automatic model_clear();
    m_pc     = '0;
    m_q      = {};
    m_halted = 0;
    m_fetch  = 0;
    m_flush  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_clear();
    #12;
    rst_n = 1'b1;
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    bit pop;
    bit push;
    logic [31:0] w;
    @(posedge clk);
    pop  = (m_q.size() != 0) && bus.id_ready;
    push = en && !m_halted && !bus.br_taken && ((m_q.size() < DEPTH) || pop);
    if (bus.br_taken) begin
      m_q      = {};
      m_pc     = bus.br_target;
      m_halted = 0;
      if (m_flush < 65535) m_flush++;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        w = mem[m_pc[7:0]];
        m_q.push_back({w, m_pc + 32'd1});
        if (w[31:26] == 6'h3f) m_halted = 1;
        m_pc = m_pc + 32'd1;
        m_fetch++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #3;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", q_count); end
    checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.imem_addr); end
    checks++; if ({bus.id_ir, bus.id_npc} !== 64'd0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", bus.id_ir, bus.id_npc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_ir !== 32'h2000_0000 + k - 1 || bus.id_npc !== k || q_count !== 3'd1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b ir=%h npc=%h cnt=%0d expected v=1 ir=%h npc=%h cnt=1",
                 k, bus.id_valid, bus.id_ir, bus.id_npc, q_count, 32'h2000_0000 + k - 1, k);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 0, 0, 0);
    repeat (6) tick();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL bp_full: got %0d expected 4", q_count); end
    checks++; if (bus.imem_addr !== 32'd4) begin errors++; $display("FAIL bp_pc: got %h expected 4", bus.imem_addr); end
    checks++; if (bus.id_ir !== 32'h2000_0000) begin errors++; $display("FAIL bp_hold: got %h expected 20000000", bus.id_ir); end
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (q_count !== 3'd4 || bus.id_ir !== 32'h2000_0000 + k || bus.imem_addr !== 32'd4 + k) begin
        errors++;
        $display("FAIL bp_stream_%0d: got cnt=%0d ir=%h pc=%h expected cnt=4 ir=%h pc=%h",
                 k, q_count, bus.id_ir, bus.imem_addr, 32'h2000_0000 + k, 32'd4 + k);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0);
    repeat (3) tick();
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", q_count); end
    drive(1, 1, 1, 32'h10);
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || q_count !== 3'd0 || bus.imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL flush_empty: got v=%b cnt=%0d pc=%h expected v=0 cnt=0 pc=10", bus.id_valid, q_count, bus.imem_addr);
    end
    drive(1, 1, 0, 0);
    tick();
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_ir !== 32'h2000_0010 || bus.id_npc !== 32'h11) begin
      errors++;
      $display("FAIL flush_target: got v=%b ir=%h npc=%h expected v=1 ir=20000010 npc=11", bus.id_valid, bus.id_ir, bus.id_npc);
    end
    // PC wrap at the top of the address space.
    drive(1, 1, 1, 32'hFFFF_FFFF);
    tick();
    drive(1, 1, 0, 0);
    tick();
    checks++;
    if (bus.imem_addr !== 32'd0 || bus.id_npc !== 32'd0 || bus.id_ir !== mem[255]) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h npc=%h ir=%h expected pc=0 npc=0 ir=%h", bus.imem_addr, bus.id_npc, bus.id_ir, mem[255]);
    end
  endtask

  task automatic test_halt();
    mem[5] = 32'hFC00_0000;
    do_reset();
    drive(1, 1, 0, 0);
    repeat (6) tick();
    checks++;
    if (halted !== 1'b1 || bus.imem_addr !== 32'd6 || bus.id_ir !== 32'hFC00_0000 || bus.id_npc !== 32'd6) begin
      errors++;
      $display("FAIL halt_enter: got h=%b pc=%h ir=%h npc=%h expected h=1 pc=6 ir=fc000000 npc=6",
               halted, bus.imem_addr, bus.id_ir, bus.id_npc);
    end
    repeat (2) tick();
    checks++;
    if (bus.id_valid !== 1'b0 || q_count !== 3'd0 || bus.imem_addr !== 32'd6 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_drain: got v=%b cnt=%0d pc=%h h=%b expected v=0 cnt=0 pc=6 h=1",
               bus.id_valid, q_count, bus.imem_addr, halted);
    end
    drive(1, 1, 1, 32'd0);
    tick();
    checks++;
    if (halted !== 1'b0 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL halt_resume: got h=%b pc=%h expected h=0 pc=0", halted, bus.imem_addr);
    end
    drive(1, 1, 0, 0);
    tick();
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_ir !== 32'h2000_0000) begin
      errors++;
      $display("FAIL halt_refetch: got v=%b ir=%h expected v=1 ir=20000000", bus.id_valid, bus.id_ir);
    end
    mem[5] = 32'h2000_0005;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1, 0, 0, 0);
    repeat (5) tick();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL mid_full: got %0d expected 4", q_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || q_count !== 3'd0 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b cnt=%0d pc=%h expected v=0 cnt=0 pc=0", bus.id_valid, q_count, bus.imem_addr);
    end
    model_clear();
    #2;
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    checks++;
    if (bus.id_ir !== 32'h2000_0000 || bus.id_npc !== 32'd1) begin
      errors++;
      $display("FAIL mid_restart: got ir=%h npc=%h expected ir=20000000 npc=1", bus.id_ir, bus.id_npc);
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    do_reset();
    drive(1, 1, 0, 0);
    repeat (10) tick();
    drive(1, 1, 1, 32'd0);
    repeat (2) tick();
    drive(0, 0, 0, 0);
    checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL stats_fetch: got %0d expected 10", fetch_cnt); end
    checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL stats_flush: got %0d expected 2", flush_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3f;
      else if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
      mem[i] = w;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tgt = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, tgt);
      tick();
      checks++;
      if (bus.id_valid !== (m_q.size() != 0) || int'(q_count) !== m_q.size() ||
          bus.imem_addr !== m_pc || halted !== m_halted) begin
        errors++;
        $display("FAIL rand_state_%0d: got v=%b cnt=%0d pc=%h h=%b expected v=%b cnt=%0d pc=%h h=%b",
                 c, bus.id_valid, q_count, bus.imem_addr, halted, m_q.size() != 0, m_q.size(), m_pc, m_halted);
      end
      if (m_q.size() != 0) begin
        checks++;
        if ({bus.id_ir, bus.id_npc} !== m_q[0]) begin
          errors++;
          $display("FAIL rand_head_%0d: got %h/%h expected %h/%h", c, bus.id_ir, bus.id_npc, m_q[0][63:32], m_q[0][31:0]);
        end
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (fetch_cnt !== 32'(m_fetch) || flush_cnt !== 16'(m_flush)) begin
        errors++;
        $display("FAIL rand_stats_%0d: got %0d/%0d expected %0d/%0d", c, fetch_cnt, flush_cnt, m_fetch, m_flush);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + 32'(i);
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_halt();
    test_reset_midstream();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_fetch_queue.md
Name: mips_fetch_queue

Overview:
- Instruction-fetch stage for the mips32 5-stage pipeline; sits directly upstream of the ID stage and replaces the bare PC/IF_ID register pair.
- Owns the PC and reads code memory (word-addressed, PC+1 sequencing).
- Buffers fetched words in a small prefetch FIFO and presents {IR, NPC} to decode under a valid/ready handshake.
- Flushes on taken branch/jump from EX/MEM and stops fetching at HLT.

Parameters:
- DEPTH, 4, prefetch FIFO entries; must be a power of 2, >= 2.
- PTR_W, 2, log2(DEPTH).
- HLT_OP, 6'b111111, opcode (IR[31:26]) that stops fetching.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  fetch enable; 0 freezes PC and pushes, pops still allowed.
- imem_addr  output  32  code-memory word address (= PC).
- imem_rdata  input  32  code-memory word; combinational read of imem_addr, same cycle.
- br_taken  input  1  EX_MEM condition; redirect request.
- br_target  input  32  EX_MEM ALU result; redirect address.
- id_ready  input  1  decode accepts head entry this cycle.
- id_valid  output  1  head entry valid.
- id_ir  output  32  head instruction word.
- id_npc  output  32  head next-PC (fetch address + 1).
- q_count  output  PTR_W+1  current FIFO occupancy, 0..DEPTH.
- halted  output  1  FSM is in HALTED.

Behaviour:
- Reset (async, rst_n=0):
  - PC=0, FIFO empty, rd/wr pointers=0, q_count=0.
  - id_valid=0; id_ir=0 and id_npc=0 (head storage cleared).
  - halted=0, FSM=FETCH.
  - Reset mid-operation discards all entries immediately.
- FSM states:
  - FETCH: normal sequential fetch.
  - HALTED: no pushes, PC holds.
- FSM transitions:
  - FETCH -> HALTED when a pushed word has IR[31:26]==HLT_OP. The HLT word itself is enqueued.
  - HALTED -> FETCH only on br_taken or reset.
- pop = id_valid & id_ready.
- push = en & (state==FETCH) & ~br_taken & (q_count<DEPTH | pop).
  - A full FIFO with a simultaneous pop accepts a push in the same cycle.
- On push, at the clock edge:
  - write {imem_rdata, PC+1} at wr_ptr.
  - wr_ptr++ (wraps mod DEPTH).
  - PC <= PC+1 (32-bit, wraps 0xFFFFFFFF->0).
- On pop: rd_ptr++ (wraps mod DEPTH).
- q_count:
  - +1 on push only, -1 on pop only.
  - unchanged on push+pop.
  - never exceeds DEPTH, never underflows.
- Head outputs:
  - id_valid = (q_count!=0).
  - id_ir/id_npc driven combinationally from entry[rd_ptr].
  - Stable while id_valid & ~id_ready.
- br_taken (highest priority after reset), at the edge:
  - PC <= br_target.
  - FIFO emptied (pointers to 0, q_count=0).
  - No push; the concurrent pop is discarded.
  - FSM -> FETCH.
  - id_valid=0 for exactly one cycle, then the target instruction appears if en=1.
- Latency:
  - Word at address A is enqueued at the first edge where PC==A and push=1.
  - It is visible at id_valid/id_ir in the following cycle.
- en=0: PC, wr_ptr frozen; decode may drain FIFO.
- br_taken with en=0: still redirects and flushes.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds output ports fetch_cnt [31:0] and flush_cnt [15:0].
  - fetch_cnt increments on every push; wraps.
  - flush_cnt increments on every br_taken edge; saturates at 16'hFFFF.
  - Both cleared by rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, en=1, id_ready=1, memory word i = 0x2000_0000+i:
  - cycle 1 id_ir=0x20000000, id_npc=1.
  - One instruction per cycle thereafter.
  - q_count stays 1.
- id_ready=0 for 6 cycles, en=1:
  - q_count reaches 4; PC stops at 4.
  - id_ir holds 0x20000000.
  - Raise id_ready with en=1: continuous pops and pushes, q_count stays 4.
- FIFO holds 3 entries, br_taken=1 with br_target=0x10:
  - next cycle id_valid=0, q_count=0.
  - following cycle id_ir=mem[0x10], id_npc=0x11.
- Word at addr 5 = 0xFC000000 (HLT_OP):
  - pushes stop after addr 5; halted=1; PC=6.
  - FIFO drains to empty.
  - br_taken to 0 resumes fetch; halted=0.
- rst_n pulsed low mid-stream with FIFO full:
  - immediately id_valid=0, q_count=0, imem_addr=0.
  - Restarts at addr 0 after release.
- With FETCH_STATS_EN: 10 pushes and 2 flushes -> fetch_cnt=10, flush_cnt=2.
